// File: rtl/network_layer_tx_arbiter_if.sv
// Packet word bundle shared by the arbiter inputs and the merged output link.
// Ready is carried as a separate scalar port so each stream keeps its own accept name.
interface network_layer_tx_arbiter_if #(
  parameter int HDR_W  = 16,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              first;
  logic              last;
  logic [HDR_W-1:0]  header;
  logic [DATA_W-1:0] data;

  modport master (output valid, first, last, header, data);
  modport slave  (input  valid, first, last, header, data);
endinterface

// File: rtl/network_layer_tx_arbiter.sv
// Packet-atomic round-robin merge of the pass-through and user streams onto layer_tx.
// Optional per-source packet counters are enabled with `define NET_TX_PKT_COUNT_EN.
module network_layer_tx_arbiter #(
  parameter bit INIT_PRIO   = 1'b0,
  parameter bit STRICT_PASS = 1'b0,
  parameter int HDR_W       = 16,
  parameter int DATA_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  network_layer_tx_arbiter_if.slave         passing_packet_rx,
  output logic                              passing_packet_rx_ready,
  network_layer_tx_arbiter_if.slave         user_layer_tx,
  output logic                              user_layer_tx_ready,
  network_layer_tx_arbiter_if.master        layer_tx,
  input  logic                              layer_tx_ready,
  output logic [7:0]                        tx_error_status
`ifdef NET_TX_PKT_COUNT_EN
  ,
  output logic [31:0]                       pass_pkt_count,
  output logic [31:0]                       user_pkt_count
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK_PASS = 2'd1, LOCK_USER = 2'd2} state_t;

  state_t            state;
  logic              prio;        // 0 = passing holds priority, 1 = user
  logic              out_vld;
  logic              out_first, out_last;
  logic [HDR_W-1:0]  out_hdr;
  logic [DATA_W-1:0] out_data;

  logic grant_any, grant_user, out_free;
  logic acc_p, acc_u, acc, in_first, in_last, pkt_done, proto_err;

  // Grant depends only on state, priority and input valids, never on data fields.
  always_comb begin
    grant_any  = 1'b0;
    grant_user = 1'b0;
    case (state)
      IDLE: begin
        grant_any = passing_packet_rx.valid | user_layer_tx.valid;
        if (passing_packet_rx.valid & user_layer_tx.valid)
          grant_user = STRICT_PASS ? 1'b0 : prio;
        else
          grant_user = user_layer_tx.valid;
      end
      LOCK_PASS: grant_any = 1'b1;
      LOCK_USER: begin
        grant_any  = 1'b1;
        grant_user = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_free                = ~out_vld | layer_tx_ready;
  assign passing_packet_rx_ready = rst_n & out_free & grant_any & ~grant_user;
  assign user_layer_tx_ready     = rst_n & out_free & grant_any &  grant_user;

  assign acc_p     = passing_packet_rx_ready & passing_packet_rx.valid;
  assign acc_u     = user_layer_tx_ready & user_layer_tx.valid;
  assign acc       = acc_p | acc_u;
  assign in_first  = acc_u ? user_layer_tx.first : passing_packet_rx.first;
  assign in_last   = acc_u ? user_layer_tx.last  : passing_packet_rx.last;
  assign pkt_done  = acc & in_last;
  assign proto_err = acc & ((state == IDLE) ? ~in_first : in_first);

  // Output register: fields only move when the slot is free, so a stall holds them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_hdr   <= '0;
      out_data  <= '0;
    end else if (out_free) begin
      out_vld <= acc;
      if (acc) begin
        out_first <= in_first;
        out_last  <= in_last;
        out_hdr   <= acc_u ? user_layer_tx.header : passing_packet_rx.header;
        out_data  <= acc_u ? user_layer_tx.data   : passing_packet_rx.data;
      end
    end
  end

  assign layer_tx.valid  = out_vld;
  assign layer_tx.first  = out_first;
  assign layer_tx.last   = out_last;
  assign layer_tx.header = out_hdr;
  assign layer_tx.data   = out_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      prio            <= INIT_PRIO;
      tx_error_status <= 8'd0;
`ifdef NET_TX_PKT_COUNT_EN
      pass_pkt_count  <= 32'd0;
      user_pkt_count  <= 32'd0;
`endif
    end else begin
      // Transitions follow last even on a malformed word.
      if (acc) begin
        if (in_last)
          state <= IDLE;
        else if (state == IDLE)
          state <= acc_u ? LOCK_USER : LOCK_PASS;
      end
      if (pkt_done && !STRICT_PASS)
        prio <= ~acc_u;
      if (proto_err && tx_error_status != 8'hFF)
        tx_error_status <= tx_error_status + 8'd1;
`ifdef NET_TX_PKT_COUNT_EN
      if (pkt_done & acc_p) pass_pkt_count <= pass_pkt_count + 32'd1;
      if (pkt_done & acc_u) user_pkt_count <= user_pkt_count + 32'd1;
`endif
    end
  end

endmodule
